// File: rtl/butterfly_addr_gen.sv
// Address/control walker for the in-place two-bank FFT/NTT butterfly datapath.
// Define BUTTERFLY_ADDR_GEN_STALL_EN to add a `stall` input that freezes RUN/GAP progress.
module butterfly_addr_gen #(
    parameter int ADDR_WIDTH = 12,
    parameter int READ_LAT   = 2,
    parameter int STAGE_GAP  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef BUTTERFLY_ADDR_GEN_STALL_EN
    input  logic                  stall,
`endif
    input  logic                  start,
    input  logic                  is_dif_in,
    input  logic                  is_fft_in,
    output logic [ADDR_WIDTH-1:0] rd_addr_0,
    output logic [ADDR_WIDTH-1:0] rd_addr_1,
    output logic                  rd_en,
    output logic                  in_swap,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  dest_bank_a,
    output logic                  dest_bank_b,
    output logic [ADDR_WIDTH-1:0] dest_addr_a,
    output logic [ADDR_WIDTH-1:0] dest_addr_b,
    output logic [ADDR_WIDTH-1:0] tw_idx,
    output logic                  is_dif,
    output logic                  is_fft,
    output logic                  busy,
    output logic                  done
);
    localparam int LOGN = ADDR_WIDTH + 1;
    localparam int SW   = $clog2(LOGN);
    localparam int GW   = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int DW   = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

    typedef struct packed {
        logic                  valid;
        logic                  bankA;
        logic                  bankB;
        logic [ADDR_WIDTH-1:0] addrA;
        logic [ADDR_WIDTH-1:0] addrB;
        logic [ADDR_WIDTH-1:0] tw;
    } align_t;

`ifndef BUTTERFLY_ADDR_GEN_STALL_EN
    logic stall;
    assign stall = 1'b0;
`endif

    state_t                state_q, state_d;
    logic [SW-1:0]         stage_q, stage_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [GW-1:0]         gapCnt_q, gapCnt_d;
    logic [DW-1:0]         drainCnt_q, drainCnt_d;
    logic                  dif_q, dif_d;
    logic                  fft_q, fft_d;
    align_t                pipe_q [READ_LAT];
    align_t                entry;

    logic [ADDR_WIDTH-1:0] mask, lowBits, halfD, iAddr, jAddr;
    logic [LOGN-1:0]       idxI;
    logic [SW-1:0]         twShift;
    logic                  lastK, lastStage;

    // At s == ADDR_WIDTH the shift overflows to zero, so the mask wraps to all-ones as required.
    always_comb begin
        mask    = (ADDR_WIDTH'(1) << stage_q) - ADDR_WIDTH'(1);
        lowBits = k_q & mask;
        idxI    = {k_q & ~mask, 1'b0} | {1'b0, lowBits};
        iAddr   = idxI[LOGN-1:1];
        halfD   = (stage_q == '0) ? '0 : (ADDR_WIDTH'(1) << (stage_q - 1'b1));
        jAddr   = iAddr | halfD;
        twShift = SW'(ADDR_WIDTH) - stage_q;
        rd_en   = (state_q == RUN) && !stall;
        entry   = '0;
        if (rd_en) begin
            entry.valid = 1'b1;
            entry.bankA = idxI[0];
            entry.bankB = ~idxI[0];
            entry.addrA = iAddr;
            entry.addrB = jAddr;
            entry.tw    = lowBits << twShift;
        end
        rd_addr_0 = '0;
        rd_addr_1 = '0;
        if (rd_en) begin
            rd_addr_0 = idxI[0] ? jAddr : iAddr;
            rd_addr_1 = idxI[0] ? iAddr : jAddr;
        end
    end

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        k_d        = k_q;
        gapCnt_d   = gapCnt_q;
        drainCnt_d = drainCnt_q;
        dif_d      = dif_q;
        fft_d      = fft_q;
        lastK      = (k_q == '1);
        lastStage  = dif_q ? (stage_q == '0) : (stage_q == SW'(LOGN - 1));
        case (state_q)
            IDLE: begin
                if (start) begin
                    dif_d   = is_dif_in;
                    fft_d   = is_fft_in;
                    stage_d = is_dif_in ? SW'(LOGN - 1) : '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    k_d = k_q + 1'b1;
                    if (lastK) begin
                        k_d = '0;
                        if (lastStage) begin
                            drainCnt_d = '0;
                            state_d    = DRAIN;
                        end else begin
                            stage_d  = dif_q ? (stage_q - 1'b1) : (stage_q + 1'b1);
                            gapCnt_d = '0;
                            state_d  = (STAGE_GAP > 0) ? GAP : RUN;
                        end
                    end
                end
            end
            GAP: begin
                if (!stall) begin
                    gapCnt_d = gapCnt_q + 1'b1;
                    if (gapCnt_q == GW'(STAGE_GAP - 1)) state_d = RUN;
                end
            end
            DRAIN: begin
                drainCnt_d = drainCnt_q + 1'b1;
                if (drainCnt_q == DW'(READ_LAT)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            k_q        <= '0;
            gapCnt_q   <= '0;
            drainCnt_q <= '0;
            dif_q      <= 1'b0;
            fft_q      <= 1'b0;
            for (int n = 0; n < READ_LAT; n++) pipe_q[n] <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            k_q        <= k_d;
            gapCnt_q   <= gapCnt_d;
            drainCnt_q <= drainCnt_d;
            dif_q      <= dif_d;
            fft_q      <= fft_d;
            pipe_q[0]  <= entry;
            for (int n = 1; n < READ_LAT; n++) pipe_q[n] <= pipe_q[n-1];
        end
    end

    assign valid_a     = pipe_q[READ_LAT-1].valid;
    assign valid_b     = pipe_q[READ_LAT-1].valid;
    assign in_swap     = pipe_q[READ_LAT-1].bankA;
    assign dest_bank_a = pipe_q[READ_LAT-1].bankA;
    assign dest_bank_b = pipe_q[READ_LAT-1].bankB;
    assign dest_addr_a = pipe_q[READ_LAT-1].addrA;
    assign dest_addr_b = pipe_q[READ_LAT-1].addrB;
    assign tw_idx      = pipe_q[READ_LAT-1].tw;
    assign is_dif      = dif_q;
    assign is_fft      = fft_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DRAIN) && (drainCnt_q == DW'(READ_LAT));

    // Operands of one butterfly must always land in opposite banks.
    assert property (@(posedge clk) disable iff (rst) valid_a |-> (dest_bank_a != dest_bank_b));
endmodule

// File: tb/tb_butterfly_addr_gen.sv
// Randomized bench for butterfly_addr_gen; expectations come from a per-cycle schedule
// built out of the stage/butterfly arithmetic (honours BUTTERFLY_ADDR_GEN_STALL_EN).
module tb_butterfly_addr_gen;
    localparam int AW    = 2;
    localparam int RL    = 2;
    localparam int GAPC  = 3;
    localparam int LOGN  = AW + 1;
    localparam int HALF  = 1 << AW;
    localparam int MAXT  = 64;
    localparam int TOTAL = LOGN * HALF + (LOGN - 1) * GAPC + RL + 1;

    logic clk = 1'b0;
    logic rst, start, isDifIn, isFftIn;
`ifdef BUTTERFLY_ADDR_GEN_STALL_EN
    logic stall;
`endif
    logic [AW-1:0] rd_addr_0, rd_addr_1, dest_addr_a, dest_addr_b, tw_idx;
    logic rd_en, in_swap, valid_a, valid_b, dest_bank_a, dest_bank_b;
    logic is_dif, is_fft, busy, done;

    butterfly_addr_gen #(.ADDR_WIDTH(AW), .READ_LAT(RL), .STAGE_GAP(GAPC)) dut (
        .clk(clk), .rst(rst),
`ifdef BUTTERFLY_ADDR_GEN_STALL_EN
        .stall(stall),
`endif
        .start(start), .is_dif_in(isDifIn), .is_fft_in(isFftIn),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rd_en(rd_en), .in_swap(in_swap),
        .valid_a(valid_a), .valid_b(valid_b), .dest_bank_a(dest_bank_a), .dest_bank_b(dest_bank_b),
        .dest_addr_a(dest_addr_a), .dest_addr_b(dest_addr_b), .tw_idx(tw_idx),
        .is_dif(is_dif), .is_fft(is_fft), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checksTotal;
    int checksPassed;
    logic [4:0]  expRd  [MAXT];
    logic [10:0] expAl  [MAXT];
    logic [3:0]  expCtl [MAXT];
    bit          stallPat [MAXT];
    int          expDoneAt;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Slot list: every butterfly of every stage in visiting order, gap slots between stages.
    function automatic void buildExpected(input bit dif, input bit fft, input int rstAt);
        logic [4:0]  rdQ[$];
        logic [10:0] alQ[$];
        int s, d, i, j, tw, t;
        for (int n = 0; n < MAXT; n++) begin
            expRd[n] = '0; expAl[n] = '0; expCtl[n] = '0;
        end
        for (int n = 0; n < LOGN; n++) begin
            s = dif ? (LOGN - 1 - n) : n;
            d = 1 << s;
            for (int k = 0; k < HALF; k++) begin
                i  = (k / d) * 2 * d + (k % d);
                j  = i + d;
                tw = (k % d) * (1 << (LOGN - 1 - s));
                rdQ.push_back({1'b1, AW'((i % 2 == 0) ? i / 2 : j / 2), AW'((i % 2 == 0) ? j / 2 : i / 2)});
                alQ.push_back({1'b1, 1'b1, 1'(i % 2), 1'(i % 2), 1'(1 - i % 2), AW'(i / 2), AW'(j / 2), AW'(tw)});
            end
            if (n < LOGN - 1) begin
                for (int g = 0; g < GAPC; g++) begin
                    rdQ.push_back('0);
                    alQ.push_back('0);
                end
            end
        end
        t = 1;
        while (rdQ.size() > 0) begin
            expCtl[t] = {1'b1, 1'b0, dif, fft};
            if (!stallPat[t]) begin
                expRd[t]      = rdQ.pop_front();
                expAl[t + RL] = alQ.pop_front();
            end
            t++;
        end
        for (int n = 0; n <= RL; n++) expCtl[t + n] = {1'b1, (n == RL), dif, fft};
        expDoneAt = t + RL;
        for (int n = expDoneAt + 1; n < MAXT; n++) expCtl[n] = {2'b00, dif, fft};
        if (rstAt > 0) begin
            for (int n = rstAt + 1; n < MAXT; n++) begin
                expRd[n] = '0; expAl[n] = '0; expCtl[n] = '0;
            end
        end
    endfunction

    task automatic applyStimulus(input bit dif, input bit fft, input int midStart, input int rstAt,
                                 input int stallAt, input int stallLen);
        int valids, dones, busyCycles, doneAt, lastT;
        valids = 0; dones = 0; busyCycles = 0; doneAt = 0;
        for (int n = 0; n < MAXT; n++) stallPat[n] = 1'b0;
        for (int n = stallAt; n < stallAt + stallLen; n++) stallPat[n] = 1'b1;
        buildExpected(dif, fft, rstAt);
        lastT = (rstAt > 0) ? rstAt + 6 : expDoneAt + 3;
        @(posedge clk); #1;
        start = 1'b1; isDifIn = dif; isFftIn = fft;
        @(posedge clk); #1;
        for (int t = 1; t <= lastT; t++) begin
`ifdef BUTTERFLY_ADDR_GEN_STALL_EN
            stall = stallPat[t];
`endif
            start = (t == midStart);
            if (t == midStart) begin
                isDifIn = !dif; isFftIn = !fft;
            end
            rst = (t == rstAt);
            @(negedge clk);
            checkOutput($sformatf("rd t=%0d", t), {rd_en, rd_addr_0, rd_addr_1}, expRd[t]);
            checkOutput($sformatf("align t=%0d", t),
                        {valid_a, valid_b, in_swap, dest_bank_a, dest_bank_b, dest_addr_a, dest_addr_b, tw_idx},
                        expAl[t]);
            checkOutput($sformatf("ctl t=%0d", t), {busy, done, is_dif, is_fft}, expCtl[t]);
            if (valid_a) valids++;
            if (busy) busyCycles++;
            if (done) begin
                dones++;
                doneAt = t;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0;
`ifdef BUTTERFLY_ADDR_GEN_STALL_EN
        stall = 1'b0;
`endif
        if (rstAt > 0) begin
            checkOutput("done after reset", dones, 0);
        end else begin
            checkOutput("valid count", valids, LOGN * HALF);
            checkOutput("done count", dones, 1);
            checkOutput("busy cycles", busyCycles, TOTAL + stallLen);
            checkOutput("done cycle", doneAt, TOTAL + stallLen);
        end
    endtask

    initial begin
        int rDif, rFft, rMid, rRst, rStAt, rStLen;
        checksTotal = 0; checksPassed = 0;
        rst = 1'b1; start = 1'b0; isDifIn = 1'b0; isFftIn = 1'b0;
`ifdef BUTTERFLY_ADDR_GEN_STALL_EN
        stall = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset rd", {rd_en, rd_addr_0, rd_addr_1}, 0);
        checkOutput("reset align",
                    {valid_a, valid_b, in_swap, dest_bank_a, dest_bank_b, dest_addr_a, dest_addr_b, tw_idx}, 0);
        checkOutput("reset ctl", {busy, done, is_dif, is_fft}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
        applyStimulus(1'b1, 1'b1, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 9, 0, 0, 0);
        applyStimulus(1'b0, 1'b0, 0, 6, 0, 0);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0);
`ifdef BUTTERFLY_ADDR_GEN_STALL_EN
        applyStimulus(1'b0, 1'b0, 0, 0, 2, 5);
`endif
        for (int iter = 0; iter < 8; iter++) begin
            rDif   = int'($urandom_range(0, 1));
            rFft   = int'($urandom_range(0, 1));
            rRst   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : 0;
            rMid   = (rRst == 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 18)) : 0;
            rStAt  = 0;
            rStLen = 0;
`ifdef BUTTERFLY_ADDR_GEN_STALL_EN
            if ($urandom_range(0, 1) == 1) begin
                rStAt  = int'($urandom_range(1, 12));
                rStLen = int'($urandom_range(1, 5));
            end
`endif
            applyStimulus(rDif[0], rFft[0], rMid, rRst, rStAt, rStLen);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
